// File: rtl/multiplier_core_if.sv
// Handshake/data bundle between a requester and multiplier_core.
// Ports: a_in/b_in (N-bit operands), start (rising edge requests an operation),
//        out (2N-bit product), finish (one-cycle completion pulse), bcd (packed BCD of out).
interface multiplier_core_if #(
    parameter int N = 5
);
    localparam int BW = (((2 * N) / 3) + 1) * 4;

    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             start;
    logic [2*N-1:0]   out;
    logic             finish;
    logic [BW-1:0]    bcd;

    modport master (
        output a_in, b_in, start,
        input  out, finish, bcd
    );

    modport slave (
        input  a_in, b_in, start,
        output out, finish, bcd
    );
endinterface

// File: rtl/multiplier_core.sv
// Purpose: sequential unsigned N x N shift-add multiplier with optional binary-to-BCD view of the result.
// Latency: start rise seen at edge k -> out valid and finish high from edge k+N+1 for one cycle.
// Backpressure: none; a start rise while BUSY or DONE is dropped, not queued.
// Ports: clk, reset (async, active-high), bus (slave modport: a_in, b_in, start in; out, finish, bcd out).
// Build option: define MULTIPLIER_BCD_EN to drive bcd from out; otherwise bcd is tied to zero.
module multiplier_core #(
    parameter int N = 5
) (
    input  logic               clk,
    input  logic               reset,
    multiplier_core_if.slave   bus
);
    localparam int PW = 2 * N;
    localparam int BW = ((PW / 3) + 1) * 4;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_nxt;
    logic            start_d;
    logic [N-1:0]    a_q, a_nxt;
    logic [N-1:0]    b_q, b_nxt;
    logic [PW-1:0]   acc_q, acc_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [PW-1:0]   out_q, out_nxt;
    logic            finish_q, finish_nxt;
    logic            start_rise;

    assign start_rise = bus.start & ~start_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            start_d  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            start_d  <= bus.start;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            acc_q    <= acc_nxt;
            cnt_q    <= cnt_nxt;
            out_q    <= out_nxt;
            finish_q <= finish_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        acc_nxt    = acc_q;
        cnt_nxt    = cnt_q;
        out_nxt    = out_q;
        finish_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    a_nxt     = bus.a_in;
                    b_nxt     = bus.b_in;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // b_q is shifted right each step, so its LSB is the multiplier bit
                // for the current iteration index held in cnt_q.
                if (b_q[0]) begin
                    acc_nxt = acc_q + (PW'(a_q) << cnt_q);
                end
                b_nxt   = b_q >> 1;
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Result and pulse are registered together on the exit edge.
                out_nxt    = acc_q;
                finish_nxt = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.out    = out_q;
    assign bus.finish = finish_q;

`ifdef MULTIPLIER_BCD_EN
    // Double-dabble: before each bit shifts in, any digit >= 5 gets +3 so the
    // shift carries correctly into the next decimal digit.
    logic [BW-1:0] bcd_v;

    always_comb begin
        bcd_v = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            for (int d = 0; d < BW / 4; d++) begin
                if (bcd_v[d*4 +: 4] >= 4'd5) begin
                    bcd_v[d*4 +: 4] = bcd_v[d*4 +: 4] + 4'd3;
                end
            end
            bcd_v = {bcd_v[BW-2:0], out_q[i]};
        end
    end

    assign bus.bcd = bcd_v;
`else
    assign bus.bcd = '0;
`endif

endmodule

// File: tb/tb_multiplier_core.sv
module tb_multiplier_core;
    localparam int N = 5;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   passed;
    logic prev_fin;

    typedef struct {
        logic [9:0]  p;
        logic [15:0] b;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    multiplier_core_if #(.N(N)) bus ();

    multiplier_core #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Decimal digits computed arithmetically, independent of shift-add-3.
    function automatic logic [15:0] exp_bcd(input int v);
`ifdef MULTIPLIER_BCD_EN
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: every finish pulse must match the oldest expected result.
    initial prev_fin = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.finish === 1'b1) begin
            check("finish_single_cycle", {31'd0, prev_fin}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_finish", {31'd0, bus.finish}, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_out"}, {22'd0, bus.out}, {22'd0, e.p});
                check({e.name, "_bcd"}, {16'd0, bus.bcd}, {16'd0, e.b});
                check({e.name, "_latency"}, cyc, e.cyc);
            end
        end
        prev_fin = bus.finish;
    end

    task automatic push_exp(input string nm, input int a, input int b);
        exp_t e;
        e.p    = 10'(a * b);
        e.b    = exp_bcd(a * b);
        e.cyc  = cyc + N + 2;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < N + 8) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_completed"}, sb.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_op(input string nm, input int a, input int b);
        @(negedge clk);
        bus.a_in  = 5'(a);
        bus.b_in  = 5'(b);
        bus.start = 1'b1;
        push_exp(nm, a, b);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        passed    = 0;
        reset     = 1'b1;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", {22'd0, bus.out}, 32'd0);
        check("reset_finish", {31'd0, bus.finish}, 32'd0);
        check("reset_bcd", {16'd0, bus.bcd}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("basic_26x30", 26, 30);

        // Second op: out must hold 780 through BUSY; a start re-rise in BUSY is ignored.
        @(negedge clk);
        bus.a_in  = 5'd13;
        bus.b_in  = 5'd13;
        bus.start = 1'b1;
        push_exp("second_13x13", 13, 13);
        for (int i = 1; i <= N + 1; i++) begin
            @(negedge clk);
            check("hold_prev_out", {22'd0, bus.out}, 32'd780);
            bus.start = (i == 2);
        end
        wait_done("second_13x13");

        run_op("max_31x31", 31, 31);
        run_op("zero_0x31", 0, 31);

        // Start held high for 20 cycles with operands changing under it.
        @(negedge clk);
        bus.a_in  = 5'd21;
        bus.b_in  = 5'd19;
        bus.start = 1'b1;
        push_exp("held_21x19", 21, 19);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.a_in = 5'((i * 7 + 3) % 32);
            bus.b_in = 5'((i * 11 + 5) % 32);
        end
        bus.start = 1'b0;
        wait_done("held_21x19");

        // Reset during the third BUSY cycle aborts without a pulse.
        @(negedge clk);
        bus.a_in  = 5'd25;
        bus.b_in  = 5'd25;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_out", {22'd0, bus.out}, 32'd0);
        check("midreset_finish", {31'd0, bus.finish}, 32'd0);
        check("midreset_bcd", {16'd0, bus.bcd}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (N + 6) @(negedge clk);
        check("after_abort_out", {22'd0, bus.out}, 32'd0);

        run_op("fresh_7x9", 7, 9);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
